// File: rtl/pwm_capture_if.sv
// PWM receiver signal bundle: the PWM line in, the recovered measurement out.
// The master side drives PWM_IN and observes results; the slave side is the receiver.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             PWM_IN;
  logic [CNT_W-1:0] HIGH_CNT;
  logic [CNT_W-1:0] PERIOD_CNT;
  logic [1:0]       SELECT_OUT;
  logic             VALID;
  logic             TIMEOUT;

  modport master (
    output PWM_IN,
    input  HIGH_CNT, PERIOD_CNT, SELECT_OUT, VALID, TIMEOUT
  );

  modport slave (
    input  PWM_IN,
    output HIGH_CNT, PERIOD_CNT, SELECT_OUT, VALID, TIMEOUT
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period between rising edges and decodes duty into 2 bits.
// Optional decode compare logic is enabled by defining PWM_CAPTURE_DECODE_EN.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int MAX_CYC = 1000
) (
  input  logic          CLK,
  input  logic          RST,
  pwm_capture_if.slave  pwm
);

  typedef enum logic {ST_IDLE, ST_MEAS} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             re_q, re_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       sel_calc;

  // Edge is registered, so prev_q is the synced level aligned with re_q for counting.
  assign re_d = sync2_q & ~prev_q;

`ifdef PWM_CAPTURE_DECODE_EN
  logic [CNT_W+1:0] h4, p1, p2, p3;

  always_comb begin
    h4 = {hi_cnt_q, 2'b00};
    p1 = {2'b00, per_cnt_q};
    p2 = {1'b0, per_cnt_q, 1'b0};
    p3 = p1 + p2;
    sel_calc = 2'd0;
    if (h4 >= p3)      sel_calc = 2'd3;
    else if (h4 >= p2) sel_calc = 2'd2;
    else if (h4 >= p1) sel_calc = 2'd1;
  end
`else
  assign sel_calc = 2'b00;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      re_q      <= 1'b0;
      per_cnt_q <= '0;
      hi_cnt_q  <= '0;
      high_q    <= '0;
      period_q  <= '0;
      sel_q     <= 2'b00;
      valid_q   <= 1'b0;
      timeout_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      sync1_q   <= pwm.PWM_IN;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      re_q      <= re_d;
      per_cnt_q <= per_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      high_q    <= high_d;
      period_q  <= period_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    hi_cnt_d  = hi_cnt_q;
    high_d    = high_q;
    period_d  = period_q;
    sel_d     = sel_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (re_q) begin
          state_d   = ST_MEAS;
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
        end
      end
      ST_MEAS: begin
        // An edge landing on the timeout cycle still completes the measurement.
        if (re_q) begin
          period_d  = per_cnt_q;
          high_d    = hi_cnt_q;
          sel_d     = sel_calc;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          per_cnt_d = CNT_W'(1);
          hi_cnt_d  = CNT_W'(1);
        end else if (per_cnt_q == CNT_W'(MAX_CYC)) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          hi_cnt_d  = hi_cnt_q + CNT_W'(prev_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pwm.HIGH_CNT   = high_q;
  assign pwm.PERIOD_CNT = period_q;
  assign pwm.SELECT_OUT = sel_q;
  assign pwm.VALID      = valid_q;
  assign pwm.TIMEOUT    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: reset, steady PWM, duty sweep, timeout/resume,
// mid-run reset and the period == MAX_CYC boundary.
module tb_pwm_capture;
  localparam int CNT_W   = 16;
  localparam int MAX_CYC = 100;
`ifdef PWM_CAPTURE_DECODE_EN
  localparam bit DEC = 1'b1;
`else
  localparam bit DEC = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  pwm_capture_if #(.CNT_W(CNT_W)) pwm ();

  pwm_capture #(.CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
    .CLK (CLK),
    .RST (RST),
    .pwm (pwm)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int first_valid_cyc = -1;
  logic [31:0] cap_hi = '0, cap_per = '0, cap_sel = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (pwm.VALID === 1'b1) begin
      if (valid_cnt == 0) first_valid_cyc <= cyc;
      valid_cnt <= valid_cnt + 1;
      cap_hi    <= 32'(pwm.HIGH_CNT);
      cap_per   <= 32'(pwm.PERIOD_CNT);
      cap_sel   <= 32'(pwm.SELECT_OUT);
      $display("VALID cyc=%0d PERIOD_CNT=%0d HIGH_CNT=%0d SELECT_OUT=%0d",
               cyc, pwm.PERIOD_CNT, pwm.HIGH_CNT, pwm.SELECT_OUT);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pwm_periods(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      pwm.PWM_IN = 1'b1;
      repeat (h) tick();
      pwm.PWM_IN = 1'b0;
      repeat (l) tick();
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge CLK);
  endtask

  function automatic logic [31:0] esel(input int s);
    return DEC ? 32'(s) : 32'd0;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_mark;
    int vc;
    int sw_h[6];
    int sw_s[6];
    sw_h = '{2, 6, 10, 14, 4, 12};
    sw_s = '{0, 1, 2, 3, 1, 3};

    // Reset then idle
    RST = 1'b1;
    pwm.PWM_IN = 1'b0;
    repeat (3) tick();
    check("rst_timeout", 32'(pwm.TIMEOUT), 32'd1);
    check("rst_valid", 32'(pwm.VALID), 32'd0);
    RST = 1'b0;
    repeat (20) tick();
    check("idle_timeout", 32'(pwm.TIMEOUT), 32'd1);
    check("idle_no_valid", 32'(valid_cnt), 32'd0);
    check("idle_high", 32'(pwm.HIGH_CNT), 32'd0);
    check("idle_period", 32'(pwm.PERIOD_CNT), 32'd0);
    check("idle_sel", 32'(pwm.SELECT_OUT), 32'd0);

    // Steady H=3 L=5: first VALID three edges after the second rise is sampled
    pwm_periods(3, 5, 1);
    c_mark = cyc;
    pwm_periods(3, 5, 3);
    check("steady_first_valid_cyc", 32'(first_valid_cyc), 32'(c_mark + 4));
    check("steady_valid_cnt", 32'(valid_cnt), 32'd3);
    check("steady_period", cap_per, 32'd8);
    check("steady_high", cap_hi, 32'd3);
    check("steady_sel", cap_sel, esel(1));
    check("steady_timeout", 32'(pwm.TIMEOUT), 32'd0);

    // Duty sweep at P=16
    for (int i = 0; i < 6; i++) begin
      pwm_periods(sw_h[i], 16 - sw_h[i], 2);
      check($sformatf("sweep_h%0d_period", sw_h[i]), cap_per, 32'd16);
      check($sformatf("sweep_h%0d_high", sw_h[i]), cap_hi, 32'(sw_h[i]));
      check($sformatf("sweep_h%0d_sel", sw_h[i]), cap_sel, esel(sw_s[i]));
    end

    // Timeout: steady then held high
    pwm_periods(3, 5, 2);
    pwm.PWM_IN = 1'b1;
    c_mark = cyc;
    vc = valid_cnt;
    wait_cyc(c_mark + 103);
    check("to_before", 32'(pwm.TIMEOUT), 32'd0);
    wait_cyc(c_mark + 104);
    check("to_after", 32'(pwm.TIMEOUT), 32'd1);
    check("to_valid_cnt", 32'(valid_cnt), 32'(vc + 1));
    check("to_hold_high", 32'(pwm.HIGH_CNT), 32'd3);
    check("to_hold_period", 32'(pwm.PERIOD_CNT), 32'd8);
    check("to_hold_sel", 32'(pwm.SELECT_OUT), esel(1));

    // Resume: first rise only arms, second rise reports
    pwm.PWM_IN = 1'b0;
    repeat (5) tick();
    vc = valid_cnt;
    pwm_periods(3, 5, 1);
    check("resume_arm_timeout", 32'(pwm.TIMEOUT), 32'd1);
    check("resume_arm_no_valid", 32'(valid_cnt), 32'(vc));
    pwm_periods(3, 5, 1);
    check("resume_timeout", 32'(pwm.TIMEOUT), 32'd0);
    check("resume_valid_cnt", 32'(valid_cnt), 32'(vc + 1));
    check("resume_period", cap_per, 32'd8);
    check("resume_high", cap_hi, 32'd3);

    // Mid-run reset during a high phase, released during the low phase
    pwm.PWM_IN = 1'b1;
    repeat (2) tick();
    RST = 1'b1;
    repeat (4) tick();
    pwm.PWM_IN = 1'b0;
    repeat (2) tick();
    check("mrst_high", 32'(pwm.HIGH_CNT), 32'd0);
    check("mrst_period", 32'(pwm.PERIOD_CNT), 32'd0);
    check("mrst_sel", 32'(pwm.SELECT_OUT), 32'd0);
    check("mrst_valid", 32'(pwm.VALID), 32'd0);
    check("mrst_timeout", 32'(pwm.TIMEOUT), 32'd1);
    RST = 1'b0;
    vc = valid_cnt;
    repeat (6) tick();
    pwm_periods(6, 10, 2);
    check("mrst_valid_cnt", 32'(valid_cnt), 32'(vc + 1));
    check("mrst_period_full", cap_per, 32'd16);
    check("mrst_high_full", cap_hi, 32'd6);
    check("mrst_sel_full", cap_sel, esel(1));

    // Period exactly MAX_CYC: the edge wins over timeout
    pwm_periods(30, 70, 2);
    check("bound_period", cap_per, 32'd100);
    check("bound_high", cap_hi, 32'd30);
    check("bound_sel", cap_sel, esel(1));
    check("bound_timeout", 32'(pwm.TIMEOUT), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM receiver that measures a single-bit PWM waveform on one clock and recovers its high time, its period and a 2-bit duty level. It is the receive end of the team's PWM generator: the generator encodes `SELECT[1:0]` as a duty cycle, and this block decodes that duty cycle back into `SELECT_OUT[1:0]`. It sits next to the generator in loopback benches and at any board input that carries a PWM control line.

## Interface
- `CNT_W`, default 16: width of the high-time and period counters and outputs.
- `MAX_CYC`, default 1000: timeout, in clocks without a rising edge; must be < 2^CNT_W.
- `CLK` input, 1 bit: single clock; all logic on the rising edge.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `PWM_IN` input, 1 bit: asynchronous PWM waveform.
- `HIGH_CNT` output, CNT_W bits: high time of the last complete period, in clocks.
- `PERIOD_CNT` output, CNT_W bits: last complete period, in clocks.
- `SELECT_OUT` output, 2 bits: decoded duty level.
- `VALID` output, 1 bit: one-cycle pulse when a new measurement is loaded.
- `TIMEOUT` output, 1 bit: high while there is no valid PWM activity.

## Operation
- `PWM_IN` passes through a 2-flop synchronizer, then a third register for edge detection.
- A rising edge (re) is synced=1 while the previous synced value=0.
- States:
  - IDLE: entered on reset or on timeout; waits for re, then goes to MEAS. No VALID is produced out of IDLE; the first edge only arms the block.
  - MEAS: increments `per_cnt` every cycle, and increments `hi_cnt` in cycles where synced=1.
- On re in MEAS:
  - Load `PERIOD_CNT` = per_cnt and `HIGH_CNT` = hi_cnt.
  - Update `SELECT_OUT`, pulse `VALID`, clear `TIMEOUT`.
  - Restart per_cnt=1 and hi_cnt=1, counting the edge cycle itself.
- Counting rule: an input high for H clocks and low for L clocks yields `PERIOD_CNT`=H+L and `HIGH_CNT`=H.
- Timeout: if per_cnt reaches `MAX_CYC` in MEAS with no re, go to IDLE and set `TIMEOUT`=1. `HIGH_CNT`, `PERIOD_CNT` and `SELECT_OUT` hold their last values.
- Decode (no divider):
  - `SELECT_OUT` = floor(4·H/P), clamped to 3.
  - Implemented as compares of 4·H against P, 2P and 3P.
  - Compare width is CNT_W+2, so there is no overflow.
- Nominal encoder duties are (2s+1)/8, i.e. 12.5%, 37.5%, 62.5% and 87.5%, which sit mid-bin.
- Boundary rules:
  - A constant-high or constant-low input never gives re, so it ends in timeout.
  - re in the same cycle per_cnt reaches `MAX_CYC`: re wins. The measurement is loaded and there is no timeout.
  - H = P is impossible, because a falling edge is required between two re.

## Timing
- Reset values: `HIGH_CNT`=0, `PERIOD_CNT`=0, `SELECT_OUT`=0, `VALID`=0, `TIMEOUT`=1, state IDLE, synchronizer flops 0.
- `RST` asserted mid-measurement discards the partial counts on the next edge. A measurement in flight is never reported.
- Latency: if `PWM_IN` is first sampled 1 at edge k, re is detected in the cycle after edge k+2.
- `VALID`, the new outputs and `TIMEOUT`=0 all appear after edge k+3, coincident for exactly one cycle.
- Outputs are registered with no combinational path from `PWM_IN`.
- Minimum resolvable pulse: 1 clock high and 1 clock low. Shorter glitches may be missed; no VALID is required for them.

## Configuration
- `PWM_CAPTURE_DECODE_EN`
  - Defined: decode compare logic is present and `SELECT_OUT` behaves as above.
  - Undefined: the decode logic is removed and `SELECT_OUT` is tied to 2'b00.
- Counters, `VALID` and `TIMEOUT` are identical in both builds.

## Test plan
- Reset then idle: `RST`=1 for 3 cycles, `PWM_IN`=0 → `TIMEOUT`=1, `VALID` never pulses, all counts 0.
- Steady PWM, H=3 and L=5, repeated 4 periods → first `VALID` on the second rising edge, 3 cycles late. Every `VALID` shows `PERIOD_CNT`=8, `HIGH_CNT`=3, `SELECT_OUT`=1.
- Sweep, P=16 with H=2, 6, 10, 14 → `SELECT_OUT`=0, 1, 2, 3. Boundary H=4 gives 1; H=12 gives 3.
- Timeout: `MAX_CYC`=100, steady PWM then `PWM_IN` held 1 → `TIMEOUT` rises 100 cycles after the last re, with outputs held. Resuming PWM gives `TIMEOUT`=0 on the second re.
- Mid-run reset: assert `RST` during a high phase → outputs return to reset values. The first post-reset `VALID` reports only a full later period.
- Build without `PWM_CAPTURE_DECODE_EN`: rerun the sweep → counts are identical and `SELECT_OUT`=0 throughout.
